// File: rtl/tff_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// tff_ctrl_pkg
// Shared types for the T flip-flop counter controller.
//   state_t : controller FSM encoding
//   DIR_UP / DIR_DN : values of the captured count direction
// -----------------------------------------------------------------------------
package tff_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/tff_bank.sv
// -----------------------------------------------------------------------------
// tff_bank
// WIDTH independent T flip-flops. Each bit inverts on a rising clock edge when
// its toggle input is high and holds otherwise.
//   clk   : rising-edge clock
//   reset : asynchronous active-high clear to 0
//   t_vec : per-bit toggle enables
//   q     : flop outputs
// -----------------------------------------------------------------------------
module tff_bank #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] t_vec,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= q ^ t_vec;
        end
    end

endmodule

// File: rtl/tff_count_ctrl.sv
// -----------------------------------------------------------------------------
// tff_count_ctrl
// Sequences a tff_bank as a bounded up/down counter with a start/done
// handshake. The bank is only ever changed through its toggle vector, the
// initial load included.
//   clk    : rising-edge clock
//   reset  : asynchronous active-high clear
//   start  : begin a run (accepted in IDLE or DONE)
//   abort  : return to IDLE holding q, no done pulse
//   pause  : freeze the count while in RUN
//   up_dn  : 1 = count 0->limit, 0 = count limit->0 (captured at start)
//   limit  : terminal / initial value (captured at start)
//   q      : current bank value
//   t_vec  : toggle vector driven into the bank this cycle
//   busy   : high in LOAD and RUN
//   done   : one-cycle completion pulse (DONE state)
// -----------------------------------------------------------------------------
module tff_count_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             pause,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] t_vec,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lim_r, lim_d;
    logic             dir_r, dir_d;
    logic [WIDTH-1:0] init_val, term_val;
    logic [WIDTH-1:0] step;

    tff_bank #(.WIDTH(WIDTH)) u_bank (
        .clk   (clk),
        .reset (reset),
        .t_vec (t_vec),
        .q     (q)
    );

    assign init_val = (dir_r == DIR_DN) ? lim_r : '0;
    assign term_val = (dir_r == DIR_UP) ? lim_r : '0;

    // Ripple-carry style toggle vector: bit i toggles when every lower bit is
    // 1 (counting up) or 0 (counting down), giving a +/-1 step per edge.
    always_comb begin : step_gen
        logic carry_up;
        logic carry_dn;
        carry_up = 1'b1;
        carry_dn = 1'b1;
        step     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            step[i]  = (dir_r == DIR_UP) ? carry_up : carry_dn;
            carry_up = carry_up & q[i];
            carry_dn = carry_dn & ~q[i];
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        lim_d   = lim_r;
        dir_d   = dir_r;
        t_vec   = '0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        lim_d   = limit;
                        dir_d   = up_dn;
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
                LOAD: begin
                    t_vec   = q ^ init_val;
                    state_d = (init_val == term_val) ? DONE : RUN;
                end
                RUN: begin
                    if (!pause) begin
                        t_vec   = step;
                        state_d = ((q ^ step) == term_val) ? DONE : RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            lim_r   <= '0;
            dir_r   <= 1'b0;
        end else begin
            state_q <= state_d;
            lim_r   <= lim_d;
            dir_r   <= dir_d;
        end
    end

    assign busy = (state_q == LOAD) || (state_q == RUN);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_tff_count_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tff_count_ctrl
// Directed testbench for tff_count_ctrl (WIDTH = 4). Inputs change and
// outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_tff_count_ctrl;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset;
    logic             start;
    logic             abort;
    logic             pause;
    logic             up_dn;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] t_vec;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    tff_count_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .abort (abort),
        .pause (pause),
        .up_dn (up_dn),
        .limit (limit),
        .q     (q),
        .t_vec (t_vec),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until done rises; returns the number of edges taken, or -1.
    task automatic wait_done(input int budget, output int edges);
        edges = -1;
        for (int k = 1; k <= budget; k++) begin
            step();
            if (done) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
        up_dn = 1'b0; limit = '0;
        step();
        step();
        checks++;
        if ({q, t_vec, busy, done} !== {4'd0, 4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: q=%0d t_vec=%0d busy=%0b done=%0b, want all 0",
                     q, t_vec, busy, done);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_up_count();
        logic [WIDTH-1:0] exp_q [4] = '{4'd0, 4'd1, 4'd2, 4'd3};
        limit = 4'd3; up_dn = 1'b1; start = 1'b1;
        step();                                    // E0: IDLE -> LOAD
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL up_load_busy: busy=%0b done=%0b, want 1/0", busy, done);
        end
        for (int k = 0; k < 4; k++) begin
            step();                                // E1..E4
            checks++;
            if (q !== exp_q[k] || done !== (k == 3) || busy !== (k != 3)) begin
                errors++;
                $display("FAIL up_seq[%0d]: q=%0d done=%0b busy=%0b, want q=%0d done=%0b busy=%0b",
                         k, q, done, busy, exp_q[k], k == 3, k != 3);
            end
        end
        step();                                    // E5: back to IDLE
        checks++;
        if (q !== 4'd3 || done !== 1'b0 || t_vec !== 4'd0) begin
            errors++;
            $display("FAIL up_hold: q=%0d done=%0b t_vec=%0d, want 3/0/0", q, done, t_vec);
        end
    endtask

    task automatic test_down_load();
        logic [WIDTH-1:0] exp_q [6] = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
        limit = 4'd5; up_dn = 1'b0; start = 1'b1;
        step();                                    // LOAD with q=3
        start = 1'b0;
        checks++;
        if (t_vec !== 4'b0110) begin
            errors++;
            $display("FAIL down_load_tvec: t_vec=%b, want 0110", t_vec);
        end
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (q !== exp_q[k] || done !== (k == 5)) begin
                errors++;
                $display("FAIL down_seq[%0d]: q=%0d done=%0b, want q=%0d done=%0b",
                         k, q, done, exp_q[k], k == 5);
            end
        end
        checks++;
        if (t_vec !== 4'd0) begin
            errors++;
            $display("FAIL down_done_tvec: t_vec=%0d, want 0", t_vec);
        end
        step();
        checks++;
        if (t_vec !== 4'd0 || done !== 1'b0 || q !== 4'd0) begin
            errors++;
            $display("FAIL down_idle: t_vec=%0d done=%0b q=%0d, want 0/0/0", t_vec, done, q);
        end
    endtask

    task automatic test_pause();
        int edges;
        limit = 4'd10; up_dn = 1'b1; start = 1'b1;
        step();                                    // E0
        start = 1'b0;
        repeat (5) step();                         // E5: q=4
        pause = 1'b1;
        #1;
        checks++;
        if (q !== 4'd4 || t_vec !== 4'd0) begin
            errors++;
            $display("FAIL pause_enter: q=%0d t_vec=%0d, want 4/0", q, t_vec);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (q !== 4'd4 || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL pause_hold[%0d]: q=%0d busy=%0b done=%0b, want 4/1/0",
                         k, q, busy, done);
            end
        end
        pause = 1'b0;
        wait_done(20, edges);
        checks++;
        if (edges !== 6 || q !== 4'd10) begin
            errors++;
            $display("FAIL pause_done: edges=%0d q=%0d, want 6/10", edges, q);
        end
        step();
    endtask

    task automatic test_abort();
        limit = 4'd10; up_dn = 1'b1; start = 1'b1;
        step();                                    // E0
        start = 1'b0;
        repeat (7) step();                         // E7: q=6
        abort = 1'b1; start = 1'b1; pause = 1'b1;
        #1;
        checks++;
        if (q !== 4'd6 || t_vec !== 4'd0) begin
            errors++;
            $display("FAIL abort_cycle: q=%0d t_vec=%0d, want 6/0", q, t_vec);
        end
        step();
        abort = 1'b0; start = 1'b0; pause = 1'b0;
        checks++;
        if (q !== 4'd6 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: q=%0d busy=%0b done=%0b, want 6/0/0", q, busy, done);
        end
        step();
        checks++;
        if (q !== 4'd6 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_stay: q=%0d done=%0b busy=%0b, want 6/0/0", q, done, busy);
        end
    endtask

    task automatic test_limit_zero();
        limit = 4'd0; up_dn = 1'b1; start = 1'b1;
        step();                                    // E0: LOAD
        start = 1'b0;
        checks++;
        if (t_vec !== 4'd6 || done !== 1'b0) begin
            errors++;
            $display("FAIL zero_load: t_vec=%0d done=%0b, want 6/0", t_vec, done);
        end
        step();                                    // E1: DONE
        checks++;
        if (done !== 1'b1 || q !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: done=%0b q=%0d busy=%0b, want 1/0/0", done, q, busy);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL zero_pulse: done=%0b, want 0", done);
        end
    endtask

    task automatic test_full_range();
        int edges;
        limit = 4'd15; up_dn = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(40, edges);
        checks++;
        if (edges !== 16 || q !== 4'd15 || t_vec !== 4'd0) begin
            errors++;
            $display("FAIL full_done: edges=%0d q=%0d t_vec=%0d, want 16/15/0", edges, q, t_vec);
        end
        step();
        step();
        checks++;
        if (q !== 4'd15 || busy !== 1'b0) begin
            errors++;
            $display("FAIL full_nowrap: q=%0d busy=%0b, want 15/0", q, busy);
        end
    endtask

    task automatic test_busy_ignore();
        logic [WIDTH-1:0] exp_q [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
        limit = 4'd4; up_dn = 1'b1; start = 1'b1;
        step();                                    // E0
        start = 1'b0;
        step();                                    // E1: q=0
        start = 1'b1; limit = 4'd9; up_dn = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (k == 1) start = 1'b0;
            checks++;
            if (q !== exp_q[k] || done !== (k == 3)) begin
                errors++;
                $display("FAIL busy_ignore[%0d]: q=%0d done=%0b, want q=%0d done=%0b",
                         k, q, done, exp_q[k], k == 3);
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        int n_done = 0;
        logic [WIDTH-1:0] exp_q [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd2, 4'd1, 4'd0};
        logic             exp_d [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        limit = 4'd3; up_dn = 1'b1; start = 1'b1;
        step();                                    // E0
        limit = 4'd2; up_dn = 1'b0;                // start stays high
        for (int k = 0; k < 8; k++) begin
            step();                                // E1..E8
            if (k == 4) start = 1'b0;
            if (done) n_done++;
            checks++;
            if (q !== exp_q[k] || done !== exp_d[k]) begin
                errors++;
                $display("FAIL b2b_seq[%0d]: q=%0d done=%0b, want q=%0d done=%0b",
                         k, q, done, exp_q[k], exp_d[k]);
            end
        end
        step();
        if (done) n_done++;
        checks++;
        if (n_done !== 2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_count: dones=%0d busy=%0b, want 2/0", n_done, busy);
        end
    endtask

    task automatic test_async_reset();
        int edges;
        limit = 4'd9; up_dn = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();                         // q=5
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({q, busy, done, t_vec} !== {4'd0, 1'b0, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL async_reset: q=%0d busy=%0b done=%0b t_vec=%0d, want all 0",
                     q, busy, done, t_vec);
        end
        step();
        reset = 1'b0;
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_after: done=%0b busy=%0b, want 0/0", done, busy);
        end
        limit = 4'd2; up_dn = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(10, edges);
        checks++;
        if (edges !== 3 || q !== 4'd2) begin
            errors++;
            $display("FAIL async_rerun: edges=%0d q=%0d, want 3/2", edges, q);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_down_load();
        test_pause();
        test_abort();
        test_limit_zero();
        test_full_range();
        test_busy_ignore();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
